// File: rtl/avalon_poll_pkg.sv
// Shared op codes, response status codes and FSM state
// encoding for the Avalon polling master.
package avalon_poll_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_ERROR   = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_GAP,
    S_RESP
  } state_e;

endpackage

// File: rtl/avalon_poll_master_if.sv
// Command/response handshake plus Avalon-MM master bus
// bundle; master = the poll block, slave = its environment.
interface avalon_poll_master_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [WIDTH-1:0]      cmd_data;
  logic [WIDTH-1:0]      cmd_mask;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [1:0]            rsp_status;
  logic [ADDR_WIDTH-1:0] master_address;
  logic                  master_read;
  logic                  master_write;
  logic [WIDTH-1:0]      master_writedata;
  logic [WIDTH-1:0]      master_readdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr,
    input  cmd_data, cmd_mask,
    input  master_readdata,
    output cmd_ready, rsp_valid,
    output rsp_data, rsp_status,
    output master_address, master_read,
    output master_write, master_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr,
    output cmd_data, cmd_mask,
    output master_readdata,
    input  cmd_ready, rsp_valid,
    input  rsp_data, rsp_status,
    input  master_address, master_read,
    input  master_write, master_writedata
  );
endinterface

// File: rtl/avalon_poll_master.sv
// Single-outstanding Avalon-MM master: write, read and
// masked poll-until-match with attempt limit and gap.
module avalon_poll_master
  import avalon_poll_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 1,
  parameter int POLL_MAX     = 16,
  parameter int POLL_GAP     = 4
) (
  input logic clk,
  input logic reset,
  avalon_poll_master_if.master bus
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  status_e               status_q, status_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [WIDTH-1:0]      wr_q, wr_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            tmr_q, tmr_d;

  logic bad_cmd;
  logic wr_cmd;
  logic hit;

  assign bad_cmd = (bus.cmd_op == OP_RSVD) ||
                   (bus.cmd_addr[1:0] != 2'b00);
  assign wr_cmd  = !bad_cmd && (bus.cmd_op == OP_WRITE);
  assign hit     = (rdata_q & mask_q) == (data_q & mask_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= OP_WRITE;
      status_q <= ST_OK;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      wr_q     <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
    end else begin
      op_q     <= op_d;
      status_q <= status_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    status_d = status_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d     = op_e'(bus.cmd_op);
          data_d   = bus.cmd_data;
          mask_d   = bus.cmd_mask;
          cnt_d    = '0;
          status_d = ST_OK;
          unique case (1'b1)
            bad_cmd: begin
              state_d  = S_RESP;
              status_d = ST_ERROR;
            end
            wr_cmd: begin
              state_d = S_WRITE;
              addr_d  = bus.cmd_addr;
              wr_d    = bus.cmd_data;
            end
            default: begin
              state_d = S_READ;
              addr_d  = bus.cmd_addr;
            end
          endcase
        end
      end
      S_WRITE: state_d = S_RESP;
      S_READ: begin
        state_d = S_WAIT;
        tmr_d   = 8'(READ_LATENCY - 1);
      end
      S_WAIT: begin
        if (tmr_q == 8'd0) begin
          rdata_d = bus.master_readdata;
          state_d = (op_q == OP_POLL) ? S_CHECK
                                      : S_RESP;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_CHECK: begin
        if (hit) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == 16'(POLL_MAX)) begin
            state_d  = S_RESP;
            status_d = ST_TIMEOUT;
          end else if (POLL_GAP == 0) begin
            state_d = S_READ;
          end else begin
            state_d = S_GAP;
            tmr_d   = 8'(POLL_GAP - 1);
          end
        end
      end
      S_GAP: begin
        if (tmr_q == 8'd0) begin
          state_d = S_READ;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address/writedata are registers so they hold between accesses
  always_comb begin
    bus.cmd_ready        = (state_q == S_IDLE);
    bus.master_write     = (state_q == S_WRITE);
    bus.master_read      = (state_q == S_READ);
    bus.master_address   = addr_q;
    bus.master_writedata = wr_q;
    bus.rsp_valid        = (state_q == S_RESP);
    bus.rsp_status       = 2'b00;
    bus.rsp_data         = '0;
    if (state_q == S_RESP) begin
      bus.rsp_status = status_q;
      if (status_q != ST_ERROR) begin
        bus.rsp_data = (op_q == OP_WRITE) ? data_q
                                          : rdata_q;
      end
    end
  end

endmodule
